// File: rtl/calc_pkg.sv
// Shared constants and FSM state encoding for the display scanner.
package calc_pkg;

  localparam int unsigned NUM_DIGITS  = 4;
  localparam logic [13:0] MAX_DISPLAY = 14'd9999;
  localparam logic [3:0]  BCD_ERR     = 4'hE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    SCAN   = 2'd2
  } state_e;

endpackage

// File: rtl/split_number.sv
// Combinational binary-to-BCD conversion (double dabble) of a 14-bit value.
// Only the low four decimal digits are returned; larger values are flagged as overflow elsewhere.
module split_number (
  input  logic [13:0] value_i,
  output logic [15:0] digits_o
);

  logic [19:0] bcd;

  always_comb begin
    bcd = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int j = 0; j < 5; j++) begin
        if (bcd[4*j +: 4] >= 4'd5) begin
          bcd[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
        end
      end
      bcd = {bcd[18:0], value_i[i]};
    end
    digits_o = bcd[15:0];
  end

endmodule

// File: rtl/display_scan.sv
// Multiplexed 4-digit display driver: captures a value, splits it into BCD
// digits and strobes them one at a time with optional leading-zero blanking.
import calc_pkg::*;

module display_scan #(
  parameter int unsigned CLK_DIV       = 50000,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [13:0] number_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        enable_i,
  output logic [3:0]  digit_sel_o,
  output logic [3:0]  bcd_o,
  output logic        blank_o,
  output logic        overflow_o
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  state_e        state_q, state_d;
  logic [13:0]   value_q, value_d;
  logic [15:0]   digits_q, digits_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    index_q, index_d;
  logic          en_q, en_d;

  logic [15:0]   split_digits;
  logic          accept;
  logic [3:0]    cur_digit;
  logic [3:0]    zero_above;

  split_number u_split (
    .value_i  (value_q),
    .digits_o (split_digits)
  );

  assign ready_o    = (state_q != UPDATE);
  assign accept     = valid_i && ready_o;
  assign overflow_o = ovf_q;

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    presc_d  = presc_q;
    index_d  = index_q;
    en_d     = enable_i;

    case (state_q)
      IDLE, SCAN: begin
        if (accept) begin
          state_d = UPDATE;
          value_d = number_i;
        end
      end
      UPDATE: begin
        state_d  = SCAN;
        digits_d = split_digits;
        ovf_d    = (value_q > MAX_DISPLAY);
      end
      default: state_d = IDLE;
    endcase

    // Scan phase is free-running across new accepts so the display never jumps.
    if (enable_i && (state_q != IDLE)) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        index_d = index_q + 2'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      value_q  <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      presc_q  <= '0;
      index_q  <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      presc_q  <= presc_d;
      index_q  <= index_d;
      en_q     <= en_d;
    end
  end

  // Digit k is a leading zero when it and every more significant digit are zero.
  always_comb begin
    zero_above[3] = (digits_q[15:12] == 4'd0);
    zero_above[2] = zero_above[3] && (digits_q[11:8] == 4'd0);
    zero_above[1] = zero_above[2] && (digits_q[7:4] == 4'd0);
    zero_above[0] = 1'b0;
  end

  assign cur_digit = digits_q[{index_q, 2'b00} +: 4];

  always_comb begin
    digit_sel_o = 4'b0000;
    bcd_o       = 4'd0;
    blank_o     = 1'b1;
    if ((state_q != IDLE) && en_q) begin
      digit_sel_o = 4'b0001 << index_q;
      if (ovf_q) begin
        bcd_o   = BCD_ERR;
        blank_o = (index_q != 2'd0);
      end else begin
        bcd_o   = cur_digit;
        blank_o = (BLANK_LEADING != 0) && zero_above[index_q];
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed self-checking bench for display_scan with CLK_DIV = 4 and leading-zero blanking.
module tb_display_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] number;
  logic        valid;
  logic        enable;
  logic        ready_o;
  logic [3:0]  digit_sel_o;
  logic [3:0]  bcd_o;
  logic        blank_o;
  logic        overflow_o;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  display_scan #(
    .CLK_DIV       (4),
    .BLANK_LEADING (1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .number_i    (number),
    .valid_i     (valid),
    .ready_o     (ready_o),
    .enable_i    (enable),
    .digit_sel_o (digit_sel_o),
    .bcd_o       (bcd_o),
    .blank_o     (blank_o),
    .overflow_o  (overflow_o)
  );

  task applyStimulus(input logic v, input logic [13:0] n, input logic en);
    valid  = v;
    number = n;
    enable = en;
  endtask

  task checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task nextCycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accept a value from a ready state; returns on the first cycle showing the new digits.
  task acceptValue(input logic [13:0] n, input string tag);
    applyStimulus(1'b1, n, 1'b1);
    checkOutput({tag, "_ready_before"}, 16'(ready_o), 16'd1);
    nextCycle;
    applyStimulus(1'b0, n, 1'b1);
    checkOutput({tag, "_ready_update"}, 16'(ready_o), 16'd0);
    nextCycle;
  endtask

  task waitSel(input logic [3:0] sel, input string tag);
    int n;
    n = 0;
    while (digit_sel_o !== sel && n < 40) begin
      nextCycle;
      n++;
    end
    checkOutput({tag, "_sel"}, 16'(digit_sel_o), 16'(sel));
  endtask

  task checkDigit(input int k, input logic [3:0] expBcd, input logic expBlank,
                  input logic checkBcd, input string tag);
    waitSel(4'b0001 << k, tag);
    if (checkBcd) checkOutput({tag, "_bcd"}, 16'(bcd_o), 16'(expBcd));
    checkOutput({tag, "_blank"}, 16'(blank_o), 16'(expBlank));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 14'd0, 1'b1);
    #12;
    checkOutput("rst_ready", 16'(ready_o), 16'd1);
    checkOutput("rst_sel", 16'(digit_sel_o), 16'd0);
    checkOutput("rst_bcd", 16'(bcd_o), 16'd0);
    checkOutput("rst_blank", 16'(blank_o), 16'd1);
    checkOutput("rst_ovf", 16'(overflow_o), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle;
    checkOutput("idle_sel", 16'(digit_sel_o), 16'd0);
    checkOutput("idle_blank", 16'(blank_o), 16'd1);
    checkOutput("idle_bcd", 16'(bcd_o), 16'd0);

    $display("[TB] scan of 1234");
    applyStimulus(1'b1, 14'd1234, 1'b1);
    checkOutput("s1234_ready_idle", 16'(ready_o), 16'd1);
    nextCycle;
    checkOutput("s1234_ready_update", 16'(ready_o), 16'd0);
    applyStimulus(1'b0, 14'd0, 1'b1);
    nextCycle;
    for (int j = 0; j < 3; j++) begin
      checkOutput("s1234_d0_sel", 16'(digit_sel_o), 16'h1);
      checkOutput("s1234_d0_bcd", 16'(bcd_o), 16'd4);
      checkOutput("s1234_d0_blank", 16'(blank_o), 16'd0);
      nextCycle;
    end
    for (int j = 0; j < 12; j++) begin
      checkOutput("s1234_sel", 16'(digit_sel_o), 16'(4'b0010 << (j / 4)));
      checkOutput("s1234_bcd", 16'(bcd_o), 16'(3 - j / 4));
      checkOutput("s1234_blank", 16'(blank_o), 16'd0);
      nextCycle;
    end
    checkOutput("s1234_wrap_sel", 16'(digit_sel_o), 16'h1);
    checkOutput("s1234_wrap_bcd", 16'(bcd_o), 16'd4);

    $display("[TB] leading-zero blanking");
    acceptValue(14'd7, "v7");
    checkDigit(0, 4'd7, 1'b0, 1'b1, "v7_d0");
    checkDigit(1, 4'd0, 1'b1, 1'b0, "v7_d1");
    checkDigit(2, 4'd0, 1'b1, 1'b0, "v7_d2");
    checkDigit(3, 4'd0, 1'b1, 1'b0, "v7_d3");
    acceptValue(14'd0, "v0");
    checkDigit(0, 4'd0, 1'b0, 1'b1, "v0_d0");
    checkDigit(1, 4'd0, 1'b1, 1'b0, "v0_d1");
    checkDigit(3, 4'd0, 1'b1, 1'b0, "v0_d3");

    $display("[TB] overflow");
    acceptValue(14'd12000, "v12000");
    checkOutput("v12000_ovf", 16'(overflow_o), 16'd1);
    checkDigit(0, 4'hE, 1'b0, 1'b1, "v12000_d0");
    checkDigit(1, 4'd0, 1'b1, 1'b0, "v12000_d1");
    checkDigit(2, 4'd0, 1'b1, 1'b0, "v12000_d2");
    checkDigit(3, 4'd0, 1'b1, 1'b0, "v12000_d3");
    acceptValue(14'd9999, "v9999");
    checkOutput("v9999_ovf", 16'(overflow_o), 16'd0);
    for (int k = 0; k < 4; k++) checkDigit(k, 4'd9, 1'b0, 1'b1, "v9999");

    $display("[TB] valid held across UPDATE");
    applyStimulus(1'b1, 14'd1111, 1'b1);
    checkOutput("held_ready_a", 16'(ready_o), 16'd1);
    nextCycle;
    checkOutput("held_ready_upd1", 16'(ready_o), 16'd0);
    applyStimulus(1'b1, 14'd2222, 1'b1);
    nextCycle;
    checkOutput("held_ready_scan", 16'(ready_o), 16'd1);
    checkOutput("held_bcd_1111", 16'(bcd_o), 16'd1);
    checkOutput("held_blank_1111", 16'(blank_o), 16'd0);
    nextCycle;
    checkOutput("held_ready_upd2", 16'(ready_o), 16'd0);
    applyStimulus(1'b0, 14'd0, 1'b1);
    nextCycle;
    checkOutput("held_bcd_2222", 16'(bcd_o), 16'd2);
    for (int j = 0; j < 3; j++) begin
      checkOutput("held_no_dup_ready", 16'(ready_o), 16'd1);
      nextCycle;
    end

    $display("[TB] enable freeze");
    begin
      int n;
      n = 0;
      while (digit_sel_o === 4'b0010 && n < 40) begin
        nextCycle;
        n++;
      end
    end
    waitSel(4'b0010, "freeze_start");
    nextCycle;
    applyStimulus(1'b0, 14'd0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      nextCycle;
      checkOutput("freeze_sel", 16'(digit_sel_o), 16'd0);
      checkOutput("freeze_blank", 16'(blank_o), 16'd1);
    end
    applyStimulus(1'b0, 14'd0, 1'b1);
    nextCycle;
    checkOutput("resume_sel0", 16'(digit_sel_o), 16'h2);
    nextCycle;
    checkOutput("resume_sel1", 16'(digit_sel_o), 16'h2);
    nextCycle;
    checkOutput("resume_sel2", 16'(digit_sel_o), 16'h4);

    $display("[TB] asynchronous reset mid-scan");
    acceptValue(14'd12000, "rst12000");
    checkOutput("rst12000_ovf", 16'(overflow_o), 16'd1);
    nextCycle;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_sel", 16'(digit_sel_o), 16'd0);
    checkOutput("arst_bcd", 16'(bcd_o), 16'd0);
    checkOutput("arst_blank", 16'(blank_o), 16'd1);
    checkOutput("arst_ovf", 16'(overflow_o), 16'd0);
    checkOutput("arst_ready", 16'(ready_o), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle;
    nextCycle;
    checkOutput("post_rst_sel", 16'(digit_sel_o), 16'd0);
    checkOutput("post_rst_blank", 16'(blank_o), 16'd1);
    checkOutput("post_rst_ovf", 16'(overflow_o), 16'd0);
    acceptValue(14'd5, "v5");
    checkDigit(0, 4'd5, 1'b0, 1'b1, "v5_d0");
    checkDigit(1, 4'd0, 1'b1, 1'b0, "v5_d1");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clock cycles per digit slot (legal range 1..2^20).
REQ-002 SHALL have parameter BLANK_LEADING, default 1, enables leading-zero blanking when 1.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port number_i  input  14  unsigned value to display (0..16383).
REQ-006 SHALL have port valid_i  input  1  number_i is valid.
REQ-007 SHALL have port ready_o  output  1  block can accept a new value.
REQ-008 SHALL have port enable_i  input  1  display scan enable.
REQ-009 SHALL have port digit_sel_o  output  4  one-hot, active-high digit strobe; bit k selects digit k (0 = least significant).
REQ-010 SHALL have port bcd_o  output  4  BCD code for the strobed digit.
REQ-011 SHALL have port blank_o  output  1  strobed digit is dark.
REQ-012 SHALL have port overflow_o  output  1  held value exceeds 9999.

Function
REQ-013 SHALL accept a value only on a cycle where valid_i and ready_o are both 1; number_i is captured on that edge.
REQ-014 SHALL have FSM states IDLE (no value held), UPDATE (one cycle), SCAN.
REQ-015 SHALL transition IDLE->UPDATE and SCAN->UPDATE on accept, and UPDATE->SCAN unconditionally after one cycle.
REQ-016 SHALL drive ready_o = 0 in UPDATE and 1 in IDLE and SCAN; valid_i during UPDATE is ignored.
REQ-017 SHALL in UPDATE register four BCD digits from the captured value (thousands, hundreds, tens, units) and register overflow_o = (value > 9999).
REQ-018 SHALL show new digits on outputs on the cycle after UPDATE (accept-to-display latency 2 cycles).
REQ-019 SHALL keep a prescaler counting 0..CLK_DIV-1 while enable_i = 1 and state is SCAN or UPDATE. On terminal count it SHALL wrap to 0 and advance the digit index 0->1->2->3->0.
REQ-020 SHALL with CLK_DIV = 1 advance the index every enabled cycle.
REQ-021 SHALL not reset the prescaler or the index on a new accept; scanning continues without a phase jump.
REQ-022 SHALL with enable_i = 0 hold the prescaler and index, drive digit_sel_o = 0 and blank_o = 1; value acceptance is unaffected.
REQ-023 SHALL in IDLE drive digit_sel_o = 0, bcd_o = 0, blank_o = 1.
REQ-024 SHALL in SCAN (and UPDATE) with enable_i = 1 drive digit_sel_o = 1 << index and bcd_o = digit[index].
REQ-025 SHALL with BLANK_LEADING = 1 blank digit k (k >= 1) when digits k..3 are all zero; digit 0 is never blanked by this rule.
REQ-026 SHALL on overflow drive bcd_o = 4'hE, blank_o = 0 for digit 0, and blank_o = 1 for digits 1..3.
REQ-027 SHALL drive all outputs from registered state only, with no combinational path from any input to any output.

Reset
REQ-028 SHALL on rst_ni low immediately force: state IDLE, prescaler 0, index 0, digit registers 0, ready_o = 1, digit_sel_o = 0, bcd_o = 0, blank_o = 1, overflow_o = 0.
REQ-029 SHALL, on reset asserted mid-UPDATE or mid-SCAN, discard the held value; the first accept after release restarts from IDLE.

Structure
REQ-030 SHALL place NUM_DIGITS = 4, MAX_DISPLAY = 9999, BCD_ERR = 4'hE and the FSM state enum in shared package calc_pkg.
REQ-031 SHALL instantiate split_number as the single sub-module for digit extraction; all sequencing stays in display_scan.
REQ-032 SHALL size the prescaler at $clog2(CLK_DIV), minimum 1 bit.

Verification
REQ-033 SHALL cover: CLK_DIV = 4, accept 1234 -> ready_o low 1 cycle; strobes 0001,0010,0100,1000 each for 4 cycles with bcd 4,3,2,1, blank_o = 0.
REQ-034 SHALL cover: accept 7 with BLANK_LEADING = 1 -> digit 0 bcd 7 lit; digits 1..3 blank. Accept 0 -> digit 0 shows 0, others blank.
REQ-035 SHALL cover: accept 12000 -> overflow_o = 1, digit 0 bcd 4'hE lit, digits 1..3 blank. Then accept 9999 -> overflow_o = 0, all four digits show 9.
REQ-036 SHALL cover: valid_i held high across UPDATE with 1111 then 2222 -> 2222 accepted only on the first SCAN cycle; no value is lost or duplicated.
REQ-037 SHALL cover: enable_i low for 10 cycles mid-slot -> digit_sel_o = 0, prescaler and index frozen; scanning resumes at the same count.
REQ-038 SHALL cover: rst_ni pulsed low mid-SCAN -> all outputs take reset values asynchronously, and state is IDLE after release.
